// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: default widths, FSM state
// encoding and the reserved ROM values (end-of-song duration, rest note).
package song_pkg;

    localparam int NOTE_W_DFLT = 6;
    localparam int DUR_W_DFLT  = 6;
    localparam int IDX_W_DFLT  = 5;
    localparam int SONG_W_DFLT = 2;

    // A duration of zero marks the end of a song; note zero is a rest.
    localparam int END_DUR   = 0;
    localparam int REST_NOTE = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_ROM  = 3'd2,
        ST_DECODE    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_PAUSE     = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/song_addr_gen.sv
// Note index within the current song: clear, increment and a flag that
// marks the last word slot of the song.
module song_addr_gen
    import song_pkg::*;
#(
    parameter int IDX_W = IDX_W_DFLT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    logic [IDX_W-1:0] r_idx;

    // Index register; clear wins over increment.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == {IDX_W{1'b1}});

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM and hands {note,duration} words to the
// note player one at a time, with pause/resume, song switching and end of song.
// Build option SONG_LOOP_EN: when defined, a finished song restarts from index 0
// instead of parking in DONE.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | stopped, waiting for play
// FETCH     | ROM address presented for the current index
// WAIT_ROM  | ROM read in flight
// DECODE    | ROM word valid: end marker or note to issue
// WAIT_DONE | note issued, waiting for the note player to finish it
// PAUSE     | play low; current index re-fetched on resume
// DONE      | song finished; back to IDLE once play drops
module song_sequencer
    import song_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DFLT,
    parameter int DUR_W  = DUR_W_DFLT,
    parameter int IDX_W  = IDX_W_DFLT,
    parameter int SONG_W = SONG_W_DFLT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_play,
    input  logic [SONG_W-1:0]       i_song,
    output logic [SONG_W+IDX_W-1:0] o_rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] i_rom_data,
    output logic [NOTE_W-1:0]       o_note,
    output logic [DUR_W-1:0]        o_duration,
    output logic                    o_new_note,
    input  logic                    i_note_done,
    output logic                    o_song_done
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SONG_W-1:0]   r_song_q;
    logic [NOTE_W-1:0]   r_note;
    logic [DUR_W-1:0]    r_dur;
    logic                r_new_note;
    logic                r_song_done;

    logic [IDX_W-1:0]    w_idx;
    logic                w_last;
    logic                w_idx_clr;
    logic                w_idx_inc;
    logic                w_song_ld;
    logic                w_load;
    logic                w_new_note_nxt;
    logic                w_song_done_nxt;
    logic                w_end;
    logic                w_switch;
    logic                w_done_ok;
    logic [NOTE_W-1:0]   w_rom_note;
    logic [DUR_W-1:0]    w_rom_dur;

    assign w_rom_note = i_rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur  = i_rom_data[DUR_W-1:0];
    assign w_switch   = (i_song != r_song_q);
    // note_done coinciding with our own new_note cannot belong to that note.
    assign w_done_ok  = i_note_done && !r_new_note;

    song_addr_gen #(
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_idx_clr),
        .i_inc   (w_idx_inc),
        .o_idx   (w_idx),
        .o_last  (w_last)
    );

    assign o_rom_addr = {r_song_q, w_idx};

    // Next-state and control decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_clr       = 1'b0;
        w_idx_inc       = 1'b0;
        w_song_ld       = 1'b0;
        w_load          = 1'b0;
        w_new_note_nxt  = 1'b0;
        w_song_done_nxt = 1'b0;
        w_end           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_play) begin
                    w_song_ld   = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (!i_play) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (w_switch) begin
                    // A song change outranks everything, including note_done.
                    w_song_ld   = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = i_play ? ST_FETCH : ST_PAUSE;
                end else begin
                    case (r_state)
                        ST_FETCH: begin
                            w_state_nxt = i_play ? ST_WAIT_ROM : ST_PAUSE;
                        end
                        ST_WAIT_ROM: begin
                            w_state_nxt = i_play ? ST_DECODE : ST_PAUSE;
                        end
                        ST_DECODE: begin
                            if (!i_play) begin
                                w_state_nxt = ST_PAUSE;
                            end else if (w_rom_dur == DUR_W'(END_DUR)) begin
                                w_end = 1'b1;
                            end else begin
                                w_load         = 1'b1;
                                w_new_note_nxt = 1'b1;
                                w_state_nxt    = ST_WAIT_DONE;
                            end
                        end
                        ST_WAIT_DONE: begin
                            if (w_done_ok) begin
                                if (w_last) begin
                                    w_end = 1'b1;
                                end else begin
                                    w_idx_inc   = 1'b1;
                                    w_state_nxt = i_play ? ST_FETCH : ST_PAUSE;
                                end
                            end else if (!i_play) begin
                                w_state_nxt = ST_PAUSE;
                            end
                        end
                        ST_PAUSE: begin
                            if (i_play) begin
                                w_state_nxt = ST_FETCH;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase

        if (w_end) begin
            w_song_done_nxt = 1'b1;
`ifdef SONG_LOOP_EN
            w_idx_clr       = 1'b1;
            w_state_nxt     = i_play ? ST_FETCH : ST_PAUSE;
`else
            w_state_nxt     = ST_DONE;
`endif
        end
    end

    // State and song-select registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_song_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_song_ld) begin
                r_song_q <= i_song;
            end
        end
    end

    // Output registers: note/duration held until the next issue, single-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_note      <= NOTE_W'(REST_NOTE);
            r_dur       <= '0;
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            if (w_load) begin
                r_note <= w_rom_note;
                r_dur  <= w_rom_dur;
            end
            r_new_note  <= w_new_note_nxt;
            r_song_done <= w_song_done_nxt;
        end
    end

    assign o_note      = r_note;
    assign o_duration  = r_dur;
    assign o_new_note  = r_new_note;
    assign o_song_done = r_song_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: ROM model with two-cycle read latency, a note
// player stand-in that answers each new_note with note_done, and an
// issue-order model built from the ROM contents and the song rules.
module tb_song_sequencer;

    logic        clk;
    logic        i_reset;
    logic        i_play;
    logic [1:0]  i_song;
    logic [6:0]  o_rom_addr;
    logic [11:0] rom_q;
    logic [5:0]  o_note;
    logic [5:0]  o_duration;
    logic        o_new_note;
    logic        i_note_done;
    logic        o_song_done;

    logic [11:0] rom [0:127];
    logic [11:0] rom_d1;

    int          n_cmp;
    int          n_fail;
    bit          rst_q;
    bit          seen_rst;
    logic [11:0] exp_q [$];
    logic [11:0] held;
    int          exp_done;
    int          got_done;
    int          addr_log [$];
    int          last_addr;
    int          dly;
    int          req_n;
    int          cancel_n;
    int          pend;
    int          req_seen;
    int          can_seen;

    song_sequencer u_dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_play      (i_play),
        .i_song      (i_song),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (rom_q),
        .o_note      (o_note),
        .o_duration  (o_duration),
        .o_new_note  (o_new_note),
        .i_note_done (i_note_done),
        .o_song_done (o_song_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Songs end at the first zero duration or after the 32nd word.
    task automatic push_song(input int s, input int from);
        for (int i = from; i < 32; i++) begin
            if (rom[s*32+i][5:0] == 6'd0) begin
                exp_done++;
                return;
            end
            exp_q.push_back(rom[s*32+i]);
        end
        exp_done++;
    endtask

    task automatic wait_nn(input string name, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_new_note && n < max);
        if (!o_new_note) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: new_note not seen within %0d cycles, expected a pulse", name, max);
        end
    endtask

    task automatic wait_sd(input string name, input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_song_done && n < max);
        if (!o_song_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: song_done not seen within %0d cycles, expected a pulse", name, max);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < addr_log.size()) ? addr_log[i] : -1;
    endfunction

    task automatic do_reset();
        i_play  = 1'b0;
        i_song  = 2'd0;
        i_reset = 1'b0;
        cancel_n++;
        step();
        step();
        i_reset = 1'b1;
        step();
    endtask

    task automatic end_checks(input string name);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
        chk({name, "_song_done_count"}, got_done, exp_done);
    endtask

    // Song ROM: registered twice, so data follows the address by two cycles.
    initial begin
        forever begin
            @(posedge clk);
            rom_d1 <= rom[o_rom_addr];
            rom_q  <= rom_d1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            rst_q = !i_reset;
            if (!i_reset) seen_rst = 1'b1;
        end
    end

    // Note player stand-in: note_done dly cycles after each new_note.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_note_done = 1'b0;
            if (cancel_n != can_seen) begin
                can_seen = cancel_n;
                pend     = 0;
            end
            if (req_n != req_seen) begin
                req_seen    = req_n;
                i_note_done = 1'b1;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) i_note_done = 1'b1;
            end
            if (o_new_note) pend = dly;
        end
    end

    // Every cycle: issued words follow the model order, outputs hold between issues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                chk("reset_outputs", {o_new_note, o_song_done, o_note, o_duration}, 0);
                held = '0;
            end else if (seen_rst) begin
                if (o_new_note) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_new_note: got note %0d dur %0d, expected no issue",
                                 o_note, o_duration);
                    end else begin
                        held = exp_q.pop_front();
                        chk("issue", {o_note, o_duration}, held);
                    end
                end else begin
                    chk("hold", {o_note, o_duration}, held);
                end
                if (o_song_done) got_done++;
            end
            if (int'(o_rom_addr) != last_addr) begin
                last_addr = int'(o_rom_addr);
                addr_log.push_back(last_addr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int paused_issues;
        n_cmp = 0; n_fail = 0; exp_done = 0; got_done = 0;
        last_addr = -1; dly = 4; req_n = 0; cancel_n = 0;
        pend = 0; req_seen = 0; can_seen = 0;
        held = '0; rst_q = 1'b0; seen_rst = 1'b0;
        i_note_done = 1'b0; i_reset = 1'b0; i_play = 1'b0; i_song = 2'd0;

        for (int i = 0; i < 128; i++) rom[i] = {6'd62, 6'd5};
        rom[0]  = {6'd1, 6'd1};  rom[1]  = {6'd0, 6'd2};
        rom[2]  = {6'd3, 6'd1};  rom[3]  = {6'd4, 6'd0};
        rom[32] = {6'd5, 6'd3};  rom[33] = {6'd9, 6'd2};  rom[34] = {6'd7, 6'd0};
        rom[64] = {6'd10, 6'd2}; rom[65] = {6'd11, 6'd1}; rom[66] = {6'd63, 6'd0};
        for (int i = 0; i < 32; i++) rom[96+i] = {6'((i*3+2) % 64), 6'((i % 5) + 1)};

        do_reset();
        chk("reset_rom_addr", o_rom_addr, 0);
        chk("reset_idle_outputs", {o_new_note, o_song_done, o_note, o_duration}, 0);

        // Song 1: two notes then the end marker; start and inter-note latency.
        push_song(1, 0);
        i_song = 2'd1;
        addr_log.delete();
        i_play = 1'b1;
        wait_nn("s1_first", 20, n);
        chk("s1_play_to_new_note", n, 4);
        chk("s1_first_word", {o_note, o_duration}, {6'd5, 6'd3});
        wait_nn("s1_second", 40, n);
        chk("s1_new_note_gap", n, 8);
        chk("s1_second_word", {o_note, o_duration}, {6'd9, 6'd2});
        wait_sd("s1_done", 40);
        i_play = 1'b0;
        step();
        chk("s1_addr0", log_at(0), 32);
        chk("s1_addr1", log_at(1), 33);
        chk("s1_addr2", log_at(2), 34);
`ifdef SONG_LOOP_EN
        chk("s1_addr3", log_at(3), 32);
        chk("s1_addr_count", addr_log.size(), 4);
`else
        chk("s1_addr_count", addr_log.size(), 3);
`endif
        end_checks("s1");

        // Pause during WAIT_DONE of idx 1; idx 1 is re-issued on resume.
        do_reset();
        exp_q.push_back(rom[0]);
        exp_q.push_back(rom[1]);
        push_song(0, 1);
        i_play = 1'b1;
        wait_nn("s3_idx0", 20, n);
        wait_nn("s3_idx1", 40, n);
        i_play = 1'b0;
        paused_issues = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_new_note) paused_issues++;
        end
        chk("s3_no_issue_while_paused", paused_issues, 0);
        i_play = 1'b1;
        wait_nn("s3_reissue", 20, n);
        chk("s3_resume_to_new_note", n, 4);
        chk("s3_reissued_rest", {o_note, o_duration}, {6'd0, 6'd2});
        wait_sd("s3_done", 100);
        i_play = 1'b0;
        step();
        end_checks("s3");

        // Song switch 0 -> 2 during WAIT_DONE, then a stale note_done.
        do_reset();
        exp_q.push_back(rom[0]);
        push_song(2, 0);
        i_play = 1'b1;
        wait_nn("s4_first", 20, n);
        addr_log.delete();
        i_song = 2'd2;
        step();
        cancel_n++;
        req_n++;
        wait_sd("s4_done", 100);
        i_play = 1'b0;
        step();
        chk("s4_addr0", log_at(0), 64);
        chk("s4_addr1", log_at(1), 65);
`ifdef SONG_LOOP_EN
        chk("s4_addr_count", addr_log.size(), 4);
`else
        chk("s4_addr_count", addr_log.size(), 3);
`endif
        end_checks("s4");

        // Full 32-word song without an end marker.
        do_reset();
        dly = 1;
        push_song(3, 0);
`ifdef SONG_LOOP_EN
        exp_q.push_back(rom[96]);
`endif
        i_song = 2'd3;
        i_play = 1'b1;
        wait_sd("s5_done", 600);
`ifdef SONG_LOOP_EN
        chk("s5_addr_at_done", o_rom_addr, 96);
        wait_nn("s5_loop", 20, n);
`else
        chk("s5_addr_at_done", o_rom_addr, 127);
`endif
        i_play = 1'b0;
        step();
        dly = 4;
        end_checks("s5");

        // Reset mid-WAIT_DONE with play held high; song restarts at idx 0.
        do_reset();
        exp_q.push_back(rom[32]);
        push_song(1, 0);
        i_song = 2'd1;
        i_play = 1'b1;
        wait_nn("s6_first", 20, n);
        i_reset = 1'b0;
        step();
        chk("s6_reset_outputs", {o_new_note, o_song_done, o_note, o_duration}, 0);
        chk("s6_reset_rom_addr", o_rom_addr, 0);
        cancel_n++;
        i_reset = 1'b1;
        wait_nn("s6_restart", 20, n);
        chk("s6_release_to_new_note", n, 4);
        chk("s6_restart_word", {o_note, o_duration}, {6'd5, 6'd3});
        wait_sd("s6_done", 60);
        i_play = 1'b0;
        step();
        end_checks("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
